// File: rtl/nv_nvdla_glb_intr_sched_if.sv
// Interrupt scheduler bus: done pulses/masks/clear from the core, serialized events and status out.
// slave = scheduler side, master = the block that drives done pulses and consumes events.
interface nv_nvdla_glb_intr_sched_if;
  logic [15:0] done_intr_pd;
  logic [15:0] done_mask;
  logic        clr_vld;
  logic [3:0]  clr_idx;
  logic        evt_pvld;
  logic        evt_prdy;
  logic [4:0]  evt_pd;
  logic [15:0] pending;
  logic [15:0] ovf_status;
  logic        core_intr;

  modport master (
    output done_intr_pd, done_mask, clr_vld, clr_idx, evt_prdy,
    input  evt_pvld, evt_pd, pending, ovf_status, core_intr
  );

  modport slave (
    input  done_intr_pd, done_mask, clr_vld, clr_idx, evt_prdy,
    output evt_pvld, evt_pd, pending, ovf_status, core_intr
  );
endinterface

// File: rtl/nv_nvdla_glb_intr_sched.sv
// Captures done pulses into pending bits and serializes them round-robin into a 1-deep event register.
// Latency 2 cycles from pulse to evt_pvld when idle; evt_prdy=0 holds the event and lets pending/overflow accumulate.
module nv_nvdla_glb_intr_sched (
  input  logic                          nvdla_core_clk,
  input  logic                          nvdla_core_rstn,
  nv_nvdla_glb_intr_sched_if.slave      intr
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state_q, state_nxt;
  logic [15:0] pending_q, pending_nxt;
  logic [15:0] ovf_q, ovf_nxt;
  logic [3:0]  ptr_q;
  logic [4:0]  evt_pd_q;

  logic        gnt_found;
  logic [3:0]  gnt_idx;
  logic [3:0]  scan_idx;
  logic        gnt;
  logic [15:0] gnt_vec, set_vec, clr_vec;

  // Round-robin scan starting at ptr; first hit wins, wrapping past 15.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    scan_idx  = ptr_q;
    for (int k = 0; k < 16; k++) begin
      scan_idx = ptr_q + 4'(k);
      if (!gnt_found && pending_q[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  assign gnt     = gnt_found && ((state_q == EMPTY) || intr.evt_prdy);
  assign gnt_vec = gnt ? (16'(1) << gnt_idx) : 16'h0000;
  assign set_vec = intr.done_intr_pd & ~intr.done_mask;
  assign clr_vec = intr.clr_vld ? (16'(1) << intr.clr_idx) : 16'h0000;

  // A set on a source being granted this cycle simply re-arms it; otherwise a repeat set is an overflow.
  assign pending_nxt = (pending_q & ~gnt_vec) | set_vec;
  assign ovf_nxt     = (ovf_q & ~clr_vec) | (set_vec & pending_q & ~gnt_vec);

  always_comb begin
    state_nxt = state_q;
    if (gnt)
      state_nxt = FULL;
    else if ((state_q == FULL) && intr.evt_prdy)
      state_nxt = EMPTY;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q   <= EMPTY;
      pending_q <= 16'h0000;
      ovf_q     <= 16'h0000;
      ptr_q     <= 4'h0;
      evt_pd_q  <= 5'h00;
    end else begin
      state_q   <= state_nxt;
      pending_q <= pending_nxt;
      ovf_q     <= ovf_nxt;
      if (gnt) begin
        ptr_q    <= gnt_idx + 4'h1;
        evt_pd_q <= {ovf_q[gnt_idx], gnt_idx};
      end
    end
  end

  assign intr.evt_pvld   = (state_q == FULL);
  assign intr.evt_pd     = evt_pd_q;
  assign intr.pending    = pending_q;
  assign intr.ovf_status = ovf_q;
  assign intr.core_intr  = (state_q == FULL) | (|pending_q) | (|ovf_q);

endmodule

// File: tb/tb_nv_nvdla_glb_intr_sched.sv
// Directed bench for the interrupt scheduler; inputs change 1ns after the rising edge, outputs sampled there too.
module tb_nv_nvdla_glb_intr_sched;

  logic nvdla_core_clk = 1'b0;
  logic nvdla_core_rstn;
  int   n_cmp = 0;
  int   n_err = 0;

  nv_nvdla_glb_intr_sched_if intr ();

  nv_nvdla_glb_intr_sched dut (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .intr            (intr.slave)
  );

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge nvdla_core_clk);
    #1;
  endtask

  task automatic chk_evt(input string tag, input logic vld, input logic [4:0] pd);
    check({tag, ".pvld"}, 32'(intr.evt_pvld), 32'(vld));
    if (vld) check({tag, ".pd"}, 32'(intr.evt_pd), 32'(pd));
  endtask

  initial begin
    nvdla_core_rstn   = 1'b0;
    intr.done_intr_pd = '0;
    intr.done_mask    = '0;
    intr.clr_vld      = 1'b0;
    intr.clr_idx      = '0;
    intr.evt_prdy     = 1'b1;
    repeat (2) tick();
    check("rst.pvld", 32'(intr.evt_pvld), 0);
    check("rst.pd", 32'(intr.evt_pd), 0);
    check("rst.pending", 32'(intr.pending), 0);
    check("rst.ovf", 32'(intr.ovf_status), 0);
    check("rst.intr", 32'(intr.core_intr), 0);
    nvdla_core_rstn = 1'b1;
    tick();

    // Single pulse on bit 5: event exactly at cycle 2, core_intr cycles 1-2.
    intr.done_intr_pd = 16'h0020;
    tick(); intr.done_intr_pd = '0;
    check("single.c1.pending", 32'(intr.pending), 32'h20);
    check("single.c1.intr", 32'(intr.core_intr), 1);
    chk_evt("single.c1", 1'b0, 5'h00);
    tick();
    chk_evt("single.c2", 1'b1, 5'h05);
    check("single.c2.intr", 32'(intr.core_intr), 1);
    check("single.c2.pending", 32'(intr.pending), 0);
    tick();
    chk_evt("single.c3", 1'b0, 5'h00);
    check("single.c3.intr", 32'(intr.core_intr), 0);

    // Round robin: grant 9 to move ptr to 10, then 3,9,14 together -> 14,3,9.
    intr.done_intr_pd = 16'h0200;
    tick(); intr.done_intr_pd = '0;
    tick(); chk_evt("rr.pre", 1'b1, 5'h09);
    tick();
    intr.done_intr_pd = 16'h4208;
    tick(); intr.done_intr_pd = '0;
    check("rr.pending", 32'(intr.pending), 32'h4208);
    tick(); chk_evt("rr.g0", 1'b1, 5'h0E);
    tick(); chk_evt("rr.g1", 1'b1, 5'h03);
    tick(); chk_evt("rr.g2", 1'b1, 5'h09);
    tick(); chk_evt("rr.idle", 1'b0, 5'h00);
    // ptr should be 10 again: 11 wins over 9.
    intr.done_intr_pd = 16'h0A00;
    tick(); intr.done_intr_pd = '0;
    tick(); chk_evt("rr.ptr.g0", 1'b1, 5'h0B);
    tick(); chk_evt("rr.ptr.g1", 1'b1, 5'h09);
    tick();

    // Backpressure: bits 0,1 with prdy=0 for 5 cycles.
    intr.evt_prdy = 1'b0;
    intr.done_intr_pd = 16'h0003;
    tick(); intr.done_intr_pd = '0;
    tick();
    chk_evt("bp.first", 1'b1, 5'h00);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_evt("bp.hold", 1'b1, 5'h00);
      check("bp.hold.pending", 32'(intr.pending), 32'h0002);
    end
    intr.evt_prdy = 1'b1;
    tick(); chk_evt("bp.next", 1'b1, 5'h01);
    tick(); chk_evt("bp.idle", 1'b0, 5'h00);

    // Overflow on bit 7 while bit 0 holds the output; coincident clear loses to the set.
    intr.evt_prdy = 1'b0;
    intr.done_intr_pd = 16'h0001;
    tick(); intr.done_intr_pd = '0;
    tick(); chk_evt("ovf.hold", 1'b1, 5'h00);
    intr.done_intr_pd = 16'h0080;
    tick();
    check("ovf.first.ovf", 32'(intr.ovf_status), 0);
    intr.clr_vld = 1'b1; intr.clr_idx = 4'd7;
    tick(); intr.done_intr_pd = '0; intr.clr_vld = 1'b0;
    check("ovf.status", 32'(intr.ovf_status), 32'h0080);
    check("ovf.pending", 32'(intr.pending), 32'h0080);
    intr.evt_prdy = 1'b1;
    tick(); chk_evt("ovf.grant", 1'b1, 5'h17);
    check("ovf.grant.pending", 32'(intr.pending), 0);
    tick(); chk_evt("ovf.drain", 1'b0, 5'h00);
    check("ovf.sticky.intr", 32'(intr.core_intr), 1);
    intr.clr_vld = 1'b1; intr.clr_idx = 4'd7;
    tick(); intr.clr_vld = 1'b0;
    check("ovf.clr.status", 32'(intr.ovf_status), 0);
    check("ovf.clr.intr", 32'(intr.core_intr), 0);

    // Masking: masked pulse dropped; mask raised after capture does not cancel.
    intr.done_mask = 16'h0004;
    intr.done_intr_pd = 16'h0004;
    tick(); intr.done_intr_pd = '0;
    check("mask.pending", 32'(intr.pending), 0);
    tick(); chk_evt("mask.noevt", 1'b0, 5'h00);
    intr.done_intr_pd = 16'h0010;
    tick(); intr.done_intr_pd = '0; intr.done_mask = 16'h0014;
    check("mask.late.pending", 32'(intr.pending), 32'h0010);
    tick(); chk_evt("mask.late.evt", 1'b1, 5'h04);
    tick(); intr.done_mask = '0;

    // Reset while FULL with pending 0x00F0.
    intr.evt_prdy = 1'b0;
    intr.done_intr_pd = 16'h0008;
    tick(); intr.done_intr_pd = '0;
    tick(); chk_evt("rstmid.full", 1'b1, 5'h03);
    intr.done_intr_pd = 16'h00F0;
    tick(); intr.done_intr_pd = '0;
    check("rstmid.pending", 32'(intr.pending), 32'h00F0);
    #2 nvdla_core_rstn = 1'b0;
    #1;
    check("rstmid.pvld", 32'(intr.evt_pvld), 0);
    check("rstmid.pd", 32'(intr.evt_pd), 0);
    check("rstmid.pend0", 32'(intr.pending), 0);
    check("rstmid.intr", 32'(intr.core_intr), 0);
    tick();
    nvdla_core_rstn = 1'b1;
    intr.evt_prdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rstmid.after.pvld", 32'(intr.evt_pvld), 0);
    end
    check("rstmid.after.intr", 32'(intr.core_intr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
